// File: rtl/mux_pipe_pkg.sv
// Shared types and helpers for the registered mux pipeline stage.
package mux_pipe_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  // Select width never drops below one bit, even for a single input.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_1_w.sv
// Combinational N-input, WIDTH-bit selector with an out-of-range indication.
module mux_n_1_w
  import mux_pipe_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = clog2_min1(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] i_d,
  input  logic [SEL_W-1:0]        i_sel,
  output logic [WIDTH-1:0]        o_data,
  output logic                    o_oor
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    o_data = '0;
    o_oor  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (i_sel == SEL_W'(k)) begin
        o_data = i_d[k*WIDTH +: WIDTH];
        o_oor  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_pipe_stage.sv
// Registered N:1 mux stage with valid/ready handshake, 2-entry skid buffer,
// flush and sticky out-of-range select flag.
module mux_pipe_stage
  import mux_pipe_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = clog2_min1(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]        select,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_oor;
  logic             w_in_xfer;
  logic             w_out_xfer;

  state_e           r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_out_valid;
  logic             r_in_ready;
  logic             r_sel_err;

  mux_n_1_w #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .i_d    (d),
    .i_sel  (select),
    .o_data (w_sel_data),
    .o_oor  (w_sel_oor)
  );

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // in_ready and out_valid are flops updated alongside the state, so neither
  // has a combinational path from out_ready.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_sel_err   <= 1'b0;
    end else if (flush) begin
      r_state     <= S_EMPTY;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      if (w_in_xfer && w_sel_oor) begin
        r_sel_err <= 1'b1;
      end
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            r_main      <= w_sel_data;
            r_state     <= S_ONE;
            r_out_valid <= 1'b1;
          end
        end
        S_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_main <= w_sel_data;
          end else if (w_in_xfer) begin
            r_skid     <= w_sel_data;
            r_state    <= S_TWO;
            r_in_ready <= 1'b0;
          end else if (w_out_xfer) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        S_TWO: begin
          if (w_out_xfer) begin
            r_main     <= r_skid;
            r_skid     <= '0;
            r_state    <= S_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign sel_err   = r_sel_err;

endmodule

// File: doc/mux_pipe_stage.md
Name: mux_pipe_stage

Overview:
Parametrised N-input, W-bit registered multiplexer pipeline stage with valid/ready handshake and a 2-entry skid buffer. It is the next-generation replacement for the fixed 5-bit 2:1 gate-level select muxes in the pipelined CPU. Typical uses are destination-register selection (Rd/Rt/X30) and operand forwarding selection at a stage boundary. It adds registered output, backpressure, flush and out-of-range select detection, and sustains full throughput.

Parameters:
WIDTH, 5, bit width of each data input and of the output
NUM_IN, 2, number of data inputs (2..16)
SEL_W, $clog2(NUM_IN) (minimum 1), width of select

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
d  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
select  input  SEL_W  index of input to forward; sampled with in_valid
in_valid  input  1  upstream presents d/select this cycle
in_ready  output  1  stage can accept; registered (no combinational path from out_ready)
flush  input  1  synchronous discard of all buffered entries
out_data  output  WIDTH  selected data, registered
out_valid  output  1  out_data holds a valid entry
out_ready  input  1  downstream accepts out_data this cycle
sel_err  output  1  sticky flag: an accepted select was >= NUM_IN

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset, and is evaluated at the rising edge.
- Reset: out_valid=0, out_data=0, skid entry empty, sel_err=0, in_ready=1 from the first cycle after reset deasserts. Transfers in a reset cycle are ignored.
- Transfer rules:
  - Input transfer = in_valid && in_ready at the edge.
  - Output transfer = out_valid && out_ready at the edge.
  - in_ready = !skid_valid.
- Selected value: d[select] when select < NUM_IN. Otherwise all zeros, and sel_err is set to 1 (sticky until reset; unaffected by flush).
- States (2-bit enum):
  - EMPTY: out_valid=0.
  - ONE: main register valid, skid empty.
  - TWO: main and skid both valid, in_ready=0.
- Transitions (no flush):
  - EMPTY + in xfer -> ONE; main <= selected value.
  - ONE + in xfer + out xfer -> ONE; main <= new value.
  - ONE + in xfer, no out xfer -> TWO; skid <= new value.
  - ONE + out xfer, no in xfer -> EMPTY.
  - TWO + out xfer -> ONE; main <= skid, skid cleared. No input can be accepted in TWO.
  - Any other combination holds the current state and data.
- Latency: 1 cycle from input transfer to out_valid when EMPTY. Sustained throughput is 1 transfer/cycle while out_ready=1.
- Ordering: strictly FIFO. No entry is dropped or duplicated except by flush or reset.
- Flush: has priority over all transfers in the same cycle.
  - Next state EMPTY, out_valid=0, skid cleared.
  - An input presented in the flush cycle is discarded.
  - in_ready=1 on the next cycle.
  - out_data retains its last value (don't-care while out_valid=0).
- Stability: while out_valid=1 and out_ready=0, out_data does not change.
- Reset mid-operation: identical to the reset values above, regardless of state. Reset has priority over flush.
- Width rules:
  - NUM_IN=1 gives SEL_W=1; select=1 is out of range.
  - Non-power-of-two NUM_IN: codes NUM_IN..2^SEL_W-1 are out of range.

Decomposition:
- Package mux_pipe_pkg:
  - state enum {S_EMPTY, S_ONE, S_TWO}.
  - function clog2_min1 for SEL_W.
- Sub-module mux_n_1_w (combinational N-input, WIDTH-bit selector):
  - Outputs the selected value and an out-of-range bit.
  - Parametrised by WIDTH and NUM_IN.
  - Instantiated once, ahead of the registers.

Test Plan:
1. Reset, then WIDTH=5, NUM_IN=4; push select=2 with d2=5'h13, out_ready=1 -> out_valid=1 next cycle, out_data=5'h13, in_ready stays 1.
2. Backpressure: out_ready=0, push 5'h01 then 5'h02 -> TWO, in_ready=0 on cycle 3, a third push is not accepted. Raise out_ready -> outputs 5'h01 then 5'h02 in order, in_ready=1 after the first pop.
3. Streaming: 16 back-to-back pushes with out_ready=1, values 0..15 -> 16 outputs in order, one per cycle, no bubbles after the first.
4. Flush in TWO with a simultaneous in_valid -> next cycle out_valid=0, in_ready=1, the flushed entries and the concurrent input never appear.
5. Out-of-range: NUM_IN=3, select=3 with in_valid -> out_data=0, sel_err=1. sel_err persists through flush and is cleared only by reset.
6. Reset asserted in TWO with out_ready=1 -> next cycle out_valid=0, out_data=0, sel_err=0, in_ready=1, no output transfer is recorded.
